// File: rtl/instr_seq_if.sv
// Sequencer bus: program-load port, run control and datapath control outputs.
interface instr_seq_if #(
   parameter int unsigned PC_W = 4
);
   logic            prog_we;
   logic [PC_W-1:0] prog_addr;
   logic [9:0]      prog_data;
   logic            start;
   logic            busy;
   logic            done;
   logic [PC_W-1:0] pc;
   logic            we;
   logic [1:0]      ra1;
   logic [1:0]      ra2;
   logic [1:0]      wa;
   logic [2:0]      opcode;

   modport master (
      output prog_we, prog_addr, prog_data, start,
      input  busy, done, pc, we, ra1, ra2, wa, opcode
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, start,
      output busy, done, pc, we, ra1, ra2, wa, opcode
   );
endinterface

// File: rtl/instr_seq.sv
// Instruction sequencer: loads a small program, then fetches and issues one
// datapath control word per two cycles until HALT or the last address.
module instr_seq #(
   parameter int unsigned PC_W = 4
) (
   input logic        clk,
   input logic        rst,
   instr_seq_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** PC_W;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);

   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] wa;
      logic [1:0] ra1;
      logic [1:0] ra2;
   } ctrl_t;

   typedef struct packed {
      logic  halt;
      ctrl_t ctrl;
   } instr_t;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_FETCH = 4'b0010,
      S_EXEC  = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   state_t          state, state_n;
   instr_t          mem [DEPTH];
   instr_t          fetch_word;
   ctrl_t           ir, ir_n;
   logic [PC_W-1:0] pc_q, pc_n;
   logic            we_q, busy_q, done_q;

   // Program memory is deliberately not reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.prog_we) begin
         mem[bus.prog_addr] <= instr_t'(bus.prog_data);
      end
   end

   assign fetch_word = mem[pc_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc_q;
      ir_n    = ir;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               pc_n    = '0;
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_n    = fetch_word.ctrl;
            state_n = fetch_word.halt ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            if (pc_q == PC_LAST) begin
               state_n = S_DONE;
            end else begin
               pc_n    = pc_q + PC_W'(1);
               state_n = S_FETCH;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         ir     <= '0;
         we_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         pc_q   <= pc_n;
         ir     <= ir_n;
         we_q   <= (state_n == S_EXEC);
         busy_q <= (state_n == S_FETCH) || (state_n == S_EXEC);
         done_q <= (state_n == S_DONE);
      end
   end

   assign bus.pc     = pc_q;
   assign bus.we     = we_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.opcode = ir.opcode;
   assign bus.wa     = ir.wa;
   assign bus.ra1    = ir.ra1;
   assign bus.ra2    = ir.ra2;
endmodule

// File: tb/tb_instr_seq.sv
// Randomized self-checking bench for instr_seq against a cycle-count model.
module tb_instr_seq;
   localparam int unsigned PC_W  = 4;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [9:0] mm [DEPTH];

   instr_seq_if #(.PC_W(PC_W)) bus ();

   instr_seq #(.PC_W(PC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.start     = 1'b0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [9:0] d);
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = a;
      bus.prog_data = d;
      mm[a]         = d;
      @(negedge clk);
      bus.prog_we   = 1'b0;
   endtask

   // Model: instruction k issues after edge 2k+1; DONE after 2h+1 (HALT at h) or edge 32.
   task automatic run_prog(input bit wr, input logic [3:0] wad, input logic [9:0] wdat,
                           input bit noise);
      int h;
      int done_e;
      int i;
      @(negedge clk);
      bus.start = 1'b1;
      if (wr) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = wad;
         bus.prog_data = wdat;
         mm[wad]       = wdat;
      end
      h = DEPTH;
      for (int k = 0; k < DEPTH; k++) begin
         if (h == DEPTH && mm[k][9]) h = k;
      end
      done_e = (h < DEPTH) ? 2 * h + 1 : 2 * DEPTH;
      @(posedge clk);
      #1;
      check("e0_busy", 32'(bus.busy), 32'd1);
      check("e0_we", 32'(bus.we), 32'd0);
      check("e0_pc", 32'(bus.pc), 32'd0);
      for (int e = 1; e <= done_e + 1; e++) begin
         @(negedge clk);
         if (noise && e <= done_e) begin
            bus.start     = 1'($urandom);
            bus.prog_we   = 1'($urandom);
            bus.prog_addr = 4'($urandom);
            bus.prog_data = 10'($urandom);
         end else begin
            clear_inputs();
         end
         @(posedge clk);
         #1;
         if (e < done_e) begin
            check($sformatf("e%0d_busy", e), 32'(bus.busy), 32'd1);
            check($sformatf("e%0d_done", e), 32'(bus.done), 32'd0);
            check($sformatf("e%0d_we", e), 32'(bus.we), 32'(e % 2));
            check($sformatf("e%0d_pc", e), 32'(bus.pc), 32'(e / 2));
            if (e % 2 == 1) begin
               i = (e - 1) / 2;
               check($sformatf("e%0d_opcode", e), 32'(bus.opcode), 32'(mm[i][8:6]));
               check($sformatf("e%0d_wa", e), 32'(bus.wa), 32'(mm[i][5:4]));
               check($sformatf("e%0d_ra1", e), 32'(bus.ra1), 32'(mm[i][3:2]));
               check($sformatf("e%0d_ra2", e), 32'(bus.ra2), 32'(mm[i][1:0]));
            end
         end else if (e == done_e) begin
            check($sformatf("e%0d_done_pulse", e), 32'(bus.done), 32'd1);
            check($sformatf("e%0d_done_busy", e), 32'(bus.busy), 32'd0);
            check($sformatf("e%0d_done_we", e), 32'(bus.we), 32'd0);
            check($sformatf("e%0d_done_pc", e), 32'(bus.pc), (h < DEPTH) ? 32'(h) : 32'(DEPTH - 1));
         end else begin
            check($sformatf("e%0d_idle_done", e), 32'(bus.done), 32'd0);
            check($sformatf("e%0d_idle_busy", e), 32'(bus.busy), 32'd0);
            check($sformatf("e%0d_idle_we", e), 32'(bus.we), 32'd0);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      for (int k = 0; k < DEPTH; k++) mm[k] = 10'h200;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_we", 32'(bus.we), 32'd0);
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_fields", 32'({bus.opcode, bus.wa, bus.ra1, bus.ra2}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < DEPTH; k++) write_word(4'(k), 10'h200);

      // Directed three-instruction program then HALT.
      write_word(4'd0, {1'b0, 3'd1, 2'd3, 2'd1, 2'd2});
      write_word(4'd1, {1'b0, 3'd2, 2'd0, 2'd3, 2'd3});
      write_word(4'd2, {1'b0, 3'd5, 2'd2, 2'd0, 2'd1});
      write_word(4'd3, 10'h200);
      run_prog(1'b0, 4'd0, 10'd0, 1'b0);

      // Reset while issuing: everything drops at once, memory survives.
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_we", 32'(bus.we), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_we", 32'(bus.we), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_pc", 32'(bus.pc), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'({bus.busy, bus.done, bus.we}), 32'd0);
      run_prog(1'b0, 4'd0, 10'd0, 1'b0);

      // Immediate HALT.
      write_word(4'd0, 10'h200);
      run_prog(1'b0, 4'd0, 10'd0, 1'b0);

      // Full program, no HALT anywhere.
      for (int k = 0; k < DEPTH; k++) write_word(4'(k), 10'($urandom) & 10'h1ff);
      run_prog(1'b0, 4'd0, 10'd0, 1'b0);

      // Ignored start/write during a run, then rerun to confirm memory.
      write_word(4'd4, 10'h200);
      run_prog(1'b0, 4'd0, 10'd0, 1'b1);
      run_prog(1'b0, 4'd0, 10'd0, 1'b0);

      // Same-cycle write and start: the new word is what executes first.
      run_prog(1'b1, 4'd0, {1'b0, 3'd6, 2'd1, 2'd2, 2'd3}, 1'b0);

      for (int it = 0; it < 20; it++) begin
         for (int w = 0; w < 4; w++) begin
            write_word(4'($urandom), ($urandom_range(0, 5) == 0) ? 10'h200 | 10'($urandom)
                                                                  : 10'($urandom) & 10'h1ff);
         end
         run_prog(1'($urandom), 4'($urandom), 10'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
